// File: rtl/fill_arbiter_n.sv
// ---------------------------------------------------------------------------
// fill_arbiter_n
//
// Merges cache-fill write requests from NUM_CH producers into the single
// fill FIFO that feeds the memory-controller AW/W path. Selection is either
// fixed priority with starvation protection (MODE=0) or round-robin (MODE=1).
// The grant is combinational. The FIFO write port is registered, so it
// issues at most one write per cycle, one cycle after the accepting edge.
//
// Parameters
//   NUM_CH         number of request channels (1..16)
//   PAYLOAD_WIDTH  bits per request ({addr, data})
//   MODE           0 = fixed priority (channel 0 highest), 1 = round-robin
//   STARVE_THR     fixed-mode starvation limit in lost-arbitration cycles
//   SRC_WIDTH      width of the source-index output
//
// Ports
//   clk                single clock, rising edge
//   rst_n              synchronous active-low reset
//   req_valid_i        per-channel request valid
//   req_ready_o        per-channel accept, one-hot or zero
//   req_data_i         channel i at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
//   fill_fifo_afull_i  FIFO almost full; blocks all grants while high
//   fill_fifo_wren_o   registered FIFO write enable
//   fill_fifo_data_o   registered FIFO write data (holds when idle)
//   fill_fifo_src_o    registered index of the channel written (holds)
// ---------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module fill_arbiter_n #(
  parameter int NUM_CH        = 2,
  parameter int PAYLOAD_WIDTH = `AXI_ADDR_WIDTH + `AXI_DATA_WIDTH,
  parameter int MODE          = 0,
  parameter int STARVE_THR    = 8,
  parameter int SRC_WIDTH     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               req_valid_i,
  output logic [NUM_CH-1:0]               req_ready_o,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0] req_data_i,
  input  logic                            fill_fifo_afull_i,
  output logic                            fill_fifo_wren_o,
  output logic [PAYLOAD_WIDTH-1:0]        fill_fifo_data_o,
  output logic [SRC_WIDTH-1:0]            fill_fifo_src_o
);

  // Registered state
  logic                     wren_q,       wren_d;
  logic [PAYLOAD_WIDTH-1:0] data_q,       data_d;
  logic [SRC_WIDTH-1:0]     src_q,        src_d;
  logic [SRC_WIDTH-1:0]     last_grant_q, last_grant_d;

  // Combinational grant
  logic [NUM_CH-1:0]        starved;
  logic                     grant_vld;
  logic [SRC_WIDTH-1:0]     grant_idx;
  logic [PAYLOAD_WIDTH-1:0] ch_data [NUM_CH];

  // Per-channel payload slices, ready decode and starvation counters
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0] cnt_q, cnt_d;

    assign ch_data[gi]     = req_data_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign req_ready_o[gi] = grant_vld && (grant_idx == SRC_WIDTH'(gi));

    // Only meaningful in fixed-priority mode; in round-robin the counters
    // stay at zero so no channel is ever flagged as starved.
    assign starved[gi] = (MODE == 0) && req_valid_i[gi] &&
                         (cnt_q >= 8'(STARVE_THR));

    // Count cycles in which this channel wanted the FIFO but another channel
    // transferred. afull stalls make no transfer, so the count holds.
    always_comb begin
      cnt_d = cnt_q;
      if ((MODE == 0) && grant_vld) begin
        if (grant_idx == SRC_WIDTH'(gi)) begin
          cnt_d = 8'd0;
        end else if (req_valid_i[gi] && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Grant selection. Both modes are written as two ordered scans so the
  // loop indices stay constant after unrolling.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (rst_n && !fill_fifo_afull_i) begin
      if (MODE == 1) begin
        // Channels above last_grant first, then wrap to 0..last_grant.
        for (int i = 0; i < NUM_CH; i++) begin
          if (!grant_vld && req_valid_i[i] && (i > int'(last_grant_q))) begin
            grant_vld = 1'b1;
            grant_idx = SRC_WIDTH'(i);
          end
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (!grant_vld && req_valid_i[i] && (i <= int'(last_grant_q))) begin
            grant_vld = 1'b1;
            grant_idx = SRC_WIDTH'(i);
          end
        end
      end else begin
        // Lowest-index starved channel overrides plain priority.
        for (int i = 0; i < NUM_CH; i++) begin
          if (!grant_vld && starved[i]) begin
            grant_vld = 1'b1;
            grant_idx = SRC_WIDTH'(i);
          end
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (!grant_vld && req_valid_i[i]) begin
            grant_vld = 1'b1;
            grant_idx = SRC_WIDTH'(i);
          end
        end
      end
    end
  end

  // Next-state for the output register and round-robin pointer. A grant
  // always lands on a valid channel, so grant_vld is the transfer strobe.
  always_comb begin
    wren_d       = grant_vld;
    data_d       = data_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      data_d = ch_data[grant_idx];
      src_d  = grant_idx;
      if (MODE == 1) begin
        last_grant_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wren_q       <= 1'b0;
      data_q       <= '0;
      src_q        <= '0;
      last_grant_q <= SRC_WIDTH'(NUM_CH - 1);
    end else begin
      wren_q       <= wren_d;
      data_q       <= data_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign fill_fifo_wren_o = wren_q;
  assign fill_fifo_data_o = data_q;
  assign fill_fifo_src_o  = src_q;

endmodule

// File: tb/tb_fill_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_fill_arbiter_n
//
// Drives three arbiter instances from one stimulus stream:
//   inst 0: NUM_CH=4, round-robin
//   inst 1: NUM_CH=4, fixed priority, STARVE_THR=3
//   inst 2: NUM_CH=3, round-robin (sees req_valid[2:0])
// A behavioural model tracks each instance. Inputs change on the falling
// edge. req_ready is checked just after that, and the registered outputs
// are checked 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fill_arbiter_n;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    valid = '0;
  logic          afull = 1'b0;
  logic [4*PW-1:0] data_bus = '0;

  logic [3:0]    rdy_rr, rdy_fp;
  logic [2:0]    rdy_r3;
  logic          wren_rr, wren_fp, wren_r3;
  logic [PW-1:0] dout_rr, dout_fp, dout_r3;
  logic [1:0]    src_rr, src_fp, src_r3;

  always #5 clk = ~clk;

  fill_arbiter_n #(.NUM_CH(4), .PAYLOAD_WIDTH(PW), .MODE(1), .STARVE_THR(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_ready_o(rdy_rr),
    .req_data_i(data_bus), .fill_fifo_afull_i(afull),
    .fill_fifo_wren_o(wren_rr), .fill_fifo_data_o(dout_rr), .fill_fifo_src_o(src_rr));

  fill_arbiter_n #(.NUM_CH(4), .PAYLOAD_WIDTH(PW), .MODE(0), .STARVE_THR(3)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_ready_o(rdy_fp),
    .req_data_i(data_bus), .fill_fifo_afull_i(afull),
    .fill_fifo_wren_o(wren_fp), .fill_fifo_data_o(dout_fp), .fill_fifo_src_o(src_fp));

  fill_arbiter_n #(.NUM_CH(3), .PAYLOAD_WIDTH(PW), .MODE(1), .STARVE_THR(8)) u_r3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid[2:0]), .req_ready_o(rdy_r3),
    .req_data_i(data_bus[3*PW-1:0]), .fill_fifo_afull_i(afull),
    .fill_fifo_wren_o(wren_r3), .fill_fifo_data_o(dout_r3), .fill_fifo_src_o(src_r3));

  // Observed outputs gathered per instance
  logic [3:0]    o_rdy  [3];
  logic          o_wren [3];
  logic [PW-1:0] o_data [3];
  logic [1:0]    o_src  [3];
  assign o_rdy[0] = rdy_rr;  assign o_rdy[1] = rdy_fp;  assign o_rdy[2] = {1'b0, rdy_r3};
  assign o_wren[0] = wren_rr; assign o_wren[1] = wren_fp; assign o_wren[2] = wren_r3;
  assign o_data[0] = dout_rr; assign o_data[1] = dout_fp; assign o_data[2] = dout_r3;
  assign o_src[0] = src_rr;  assign o_src[1] = src_fp;  assign o_src[2] = src_r3;

  // Model configuration and state
  int            n_of    [3] = '{4, 4, 3};
  int            mode_of [3] = '{1, 0, 1};
  int            thr_of  [3] = '{8, 3, 8};
  int            m_last  [3];
  int            m_cnt   [3][4];
  logic          m_wren  [3];
  logic [PW-1:0] m_data  [3];
  int            m_src   [3];

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d cyc=%0d obs=%0h exp=%0h", tag, k, cyc_no, obs, exp);
    end
  endtask

  // Channel that should win this cycle, or -1 for no grant.
  function automatic int mgrant(int k, logic [3:0] v, logic af, logic rn);
    int n;
    n = n_of[k];
    if (!rn || af) return -1;
    if (mode_of[k] == 1) begin
      for (int s = 1; s <= n; s++) begin
        int c;
        c = (m_last[k] + s) % n;
        if (v[c]) return c;
      end
    end else begin
      for (int i = 0; i < n; i++)
        if (v[i] && m_cnt[k][i] >= thr_of[k]) return i;
      for (int i = 0; i < n; i++)
        if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [3:0] v, input logic af, input logic rn);
    int g [3];
    @(negedge clk);
    valid    = v;
    afull    = af;
    rst_n    = rn;
    data_bus = {$urandom, $urandom};
    #1;
    for (int k = 0; k < 3; k++) begin
      g[k] = mgrant(k, v, af, rn);
      check("ready", k, 32'(o_rdy[k]), (g[k] < 0) ? 32'd0 : (32'd1 << g[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        m_wren[k] = 1'b0;
        m_data[k] = '0;
        m_src[k]  = 0;
        m_last[k] = n_of[k] - 1;
        for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      end else begin
        m_wren[k] = (g[k] >= 0);
        if (g[k] >= 0) begin
          m_data[k] = data_bus[g[k]*PW +: PW];
          m_src[k]  = g[k];
          m_last[k] = g[k];
          for (int i = 0; i < n_of[k]; i++) begin
            if (i == g[k]) m_cnt[k][i] = 0;
            else if (v[i] && m_cnt[k][i] < 255) m_cnt[k][i]++;
          end
        end
      end
      check("wren", k, 32'(o_wren[k]), 32'(m_wren[k]));
      check("data", k, 32'(o_data[k]), 32'(m_data[k]));
      check("src",  k, 32'(o_src[k]),  32'(m_src[k]));
    end
    cyc_no++;
    $display("cyc=%0d v=%b af=%b rn=%b grant rr=%0d fp=%0d r3=%0d",
             cyc_no, v, af, rn, g[0], g[1], g[2]);
  endtask

  initial begin
    // Reset held 3 cycles with every channel requesting
    repeat (3) cycle(4'hF, 1'b0, 1'b0);
    // Release: channel 0 first everywhere, then rotation / starvation
    repeat (8) cycle(4'hF, 1'b0, 1'b1);
    // Two competing channels on the fixed-priority instance: 0,0,0,1,...
    repeat (8) cycle(4'h3, 1'b0, 1'b1);
    // Backpressure for 5 cycles, then resume
    repeat (5) cycle(4'hF, 1'b1, 1'b1);
    repeat (4) cycle(4'hF, 1'b0, 1'b1);
    // Reset in the cycle after a transfer
    cycle(4'hF, 1'b0, 1'b1);
    cycle(4'hF, 1'b0, 1'b0);
    repeat (3) cycle(4'hF, 1'b0, 1'b1);
    // Sparse traffic: only channel 2, alternating cycles
    for (int i = 0; i < 8; i++) cycle((i % 2 == 0) ? 4'h4 : 4'h0, 1'b0, 1'b1);
    // Single requester every cycle on the top channel
    repeat (4) cycle(4'h8, 1'b0, 1'b1);
    // Randomized traffic with occasional afull and reset
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
